// File: rtl/mux4h_arb.sv
// rtl/mux4h_arb.sv - round-robin arbiter for a shared 4-input mux with one-entry output register
// Optional locked-burst mode enabled by defining MUX4H_ARB_BURST_EN.
module mux4h_arb #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [3:0]       req,
    input  logic [3:0]       last,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    output logic [3:0]       gnt,
    output logic [2:0]       sel,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       out_src,
    output logic             out_valid,
    input  logic             out_ready
);

    typedef enum logic {IDLE, LOCK} state_t;

    state_t           state_q;
    logic [1:0]       ptr_q;
    logic [1:0]       owner_q;
    logic [WIDTH-1:0] out_data_q;
    logic [1:0]       out_src_q;
    logic             out_valid_q;

    logic             load;
    logic             accept;
    logic             cand_vld;
    logic [1:0]       cand;
    logic [1:0]       idx;
    logic [WIDTH-1:0] mux_out;

    assign load   = !out_valid_q || out_ready;
    assign accept = cand_vld && load;

    // Scan from the highest offset down so the offset nearest ptr wins.
    always_comb begin
        cand     = 2'd0;
        cand_vld = 1'b0;
        idx      = 2'd0;
        if (state_q == LOCK) begin
            cand     = owner_q;
            cand_vld = req[owner_q];
        end else begin
            for (int k = 3; k >= 0; k--) begin
                idx = ptr_q + 2'(k);
                if (req[idx]) begin
                    cand     = idx;
                    cand_vld = 1'b1;
                end
            end
        end
    end

    always_comb begin
        mux_out = d0;
        case (cand)
            2'd0:    mux_out = d0;
            2'd1:    mux_out = d1;
            2'd2:    mux_out = d2;
            default: mux_out = d3;
        endcase
    end

    // Control outputs read zero while reset is held.
    assign sel = reset_n ? {1'b0, cand} : 3'b000;
    assign gnt = (reset_n && accept) ? (4'b0001 << cand) : 4'b0000;

`ifndef MUX4H_ARB_BURST_EN
    logic unused_last;
    assign unused_last = ^last;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            ptr_q       <= 2'd0;
            owner_q     <= 2'd0;
            out_data_q  <= '0;
            out_src_q   <= 2'd0;
            out_valid_q <= 1'b0;
        end else begin
            if (accept) begin
                out_data_q  <= mux_out;
                out_src_q   <= cand;
                out_valid_q <= 1'b1;
`ifdef MUX4H_ARB_BURST_EN
                if (state_q == IDLE) begin
                    if (last[cand]) begin
                        ptr_q <= cand + 2'd1;
                    end else begin
                        state_q <= LOCK;
                        owner_q <= cand;
                    end
                end else if (last[cand]) begin
                    state_q <= IDLE;
                    ptr_q   <= owner_q + 2'd1;
                end
`else
                ptr_q <= cand + 2'd1;
`endif
            end else if (out_ready && out_valid_q) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_data  = out_data_q;
    assign out_src   = out_src_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux4h_arb.sv
// tb/tb_mux4h_arb.sv - scoreboard testbench for mux4h_arb
// Burst scenarios compile only when MUX4H_ARB_BURST_EN is defined.
module tb_mux4h_arb;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [3:0]       req;
    logic [3:0]       last;
    logic [WIDTH-1:0] d0, d1, d2, d3;
    logic [3:0]       gnt;
    logic [2:0]       sel;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       out_src;
    logic             out_valid;
    logic             out_ready;

    int n_cmp = 0;
    int n_err = 0;

    logic [WIDTH+1:0] sb[$];
    logic [WIDTH+1:0] exp_q;
    logic [WIDTH+1:0] held;

    always #5 clk = ~clk;

    mux4h_arb #(.WIDTH(WIDTH)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .last(last),
        .d0(d0), .d1(d1), .d2(d2), .d3(d3),
        .gnt(gnt), .sel(sel), .out_data(out_data), .out_src(out_src),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    function automatic logic [WIDTH-1:0] dsel(input int k);
        case (k)
            0:       return d0;
            1:       return d1;
            2:       return d2;
            default: return d3;
        endcase
    endfunction

    task automatic rand_d();
        d0 = WIDTH'($urandom);
        d1 = WIDTH'($urandom);
        d2 = WIDTH'($urandom);
        d3 = WIDTH'($urandom);
    endtask

    task automatic pop_exp();
        if (sb.size() == 0) begin
            exp_q = '1;
            n_cmp++; n_err++;
            $display("FAIL scoreboard_empty: actual size 0 required >0");
        end else begin
            exp_q = sb.pop_front();
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; req = 4'b1111; last = 4'b1111; out_ready = 1'b1;
        rand_d();
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (gnt !== 4'b0000)     begin n_err++; $display("FAIL reset_gnt: actual %b required 0000", gnt); end
        n_cmp++; if (sel !== 3'b000)      begin n_err++; $display("FAIL reset_sel: actual %b required 000", sel); end
        n_cmp++; if (out_valid !== 1'b0)  begin n_err++; $display("FAIL reset_valid: actual %b required 0", out_valid); end
        n_cmp++; if (out_data !== '0)     begin n_err++; $display("FAIL reset_data: actual %h required 00", out_data); end
        n_cmp++; if (out_src !== 2'd0)    begin n_err++; $display("FAIL reset_src: actual %0d required 0", out_src); end
        req = 4'b0000;
        @(posedge clk); #1;
        reset_n = 1'b1;
    endtask

    task automatic test_round_robin();
        for (int k = 0; k < 4; k++) begin
            req = 4'b1111; last = 4'b1111; out_ready = 1'b1;
            rand_d();
            @(negedge clk);
            n_cmp++; if (gnt !== (4'b0001 << k)) begin n_err++; $display("FAIL rr_gnt[%0d]: actual %b required %b", k, gnt, 4'b0001 << k); end
            n_cmp++; if (sel !== 3'(k))          begin n_err++; $display("FAIL rr_sel[%0d]: actual %b required %0d", k, sel, k); end
            sb.push_back({2'(k), dsel(k)});
            @(posedge clk); #1;
            pop_exp();
            held = exp_q;
            n_cmp++; if (out_valid !== 1'b1)                      begin n_err++; $display("FAIL rr_valid[%0d]: actual %b required 1", k, out_valid); end
            n_cmp++; if ({out_src, out_data} !== exp_q)           begin n_err++; $display("FAIL rr_out[%0d]: actual %h required %h", k, {out_src, out_data}, exp_q); end
        end
    endtask

    task automatic test_backpressure();
        for (int k = 0; k < 3; k++) begin
            req = 4'b0100; last = 4'b1111; out_ready = 1'b0;
            rand_d();
            @(negedge clk);
            n_cmp++; if (gnt !== 4'b0000) begin n_err++; $display("FAIL bp_gnt[%0d]: actual %b required 0000", k, gnt); end
            @(posedge clk); #1;
            n_cmp++; if (out_valid !== 1'b1)              begin n_err++; $display("FAIL bp_valid[%0d]: actual %b required 1", k, out_valid); end
            n_cmp++; if ({out_src, out_data} !== held)    begin n_err++; $display("FAIL bp_hold[%0d]: actual %h required %h", k, {out_src, out_data}, held); end
        end
        out_ready = 1'b1;
        rand_d();
        @(negedge clk);
        n_cmp++; if (gnt !== 4'b0100) begin n_err++; $display("FAIL bp_release_gnt: actual %b required 0100", gnt); end
        n_cmp++; if (sel !== 3'b010)  begin n_err++; $display("FAIL bp_release_sel: actual %b required 010", sel); end
        sb.push_back({2'd2, d2});
        @(posedge clk); #1;
        pop_exp();
        n_cmp++; if ({out_src, out_data} !== exp_q) begin n_err++; $display("FAIL bp_release_out: actual %h required %h", {out_src, out_data}, exp_q); end
        req = 4'b0000;
        @(posedge clk); #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_drain_valid: actual %b required 0", out_valid); end
    endtask

    task automatic test_burst_mix();
        logic [3:0] last_tab [4] = '{4'b0010, 4'b0010, 4'b0011, 4'b0011};
`ifdef MUX4H_ARB_BURST_EN
        int exp_tab [4] = '{0, 0, 0, 1};
`else
        int exp_tab [4] = '{0, 1, 0, 1};
`endif
        for (int k = 0; k < 4; k++) begin
            req = 4'b0011; last = last_tab[k]; out_ready = 1'b1;
            rand_d();
            @(negedge clk);
            n_cmp++; if (gnt !== (4'b0001 << exp_tab[k])) begin n_err++; $display("FAIL mix_gnt[%0d]: actual %b required %b", k, gnt, 4'b0001 << exp_tab[k]); end
            n_cmp++; if (sel !== 3'(exp_tab[k]))          begin n_err++; $display("FAIL mix_sel[%0d]: actual %b required %0d", k, sel, exp_tab[k]); end
            sb.push_back({2'(exp_tab[k]), dsel(exp_tab[k])});
            @(posedge clk); #1;
            pop_exp();
            n_cmp++; if ({out_src, out_data} !== exp_q) begin n_err++; $display("FAIL mix_out[%0d]: actual %h required %h", k, {out_src, out_data}, exp_q); end
        end
    endtask

`ifdef MUX4H_ARB_BURST_EN
    task automatic test_owner_drop();
        logic [3:0] req_tab  [5] = '{4'b0101, 4'b0001, 4'b0001, 4'b0101, 4'b0001};
        logic [3:0] last_tab [5] = '{4'b0000, 4'b0001, 4'b0001, 4'b0100, 4'b0001};
        int         exp_tab  [5] = '{2, -1, -1, 2, 0};
        for (int k = 0; k < 5; k++) begin
            req = req_tab[k]; last = last_tab[k]; out_ready = 1'b1;
            rand_d();
            @(negedge clk);
            if (exp_tab[k] < 0) begin
                n_cmp++; if (gnt !== 4'b0000) begin n_err++; $display("FAIL drop_gnt[%0d]: actual %b required 0000", k, gnt); end
                n_cmp++; if (sel !== 3'b010)  begin n_err++; $display("FAIL drop_sel[%0d]: actual %b required 010", k, sel); end
            end else begin
                n_cmp++; if (gnt !== (4'b0001 << exp_tab[k])) begin n_err++; $display("FAIL drop_gnt[%0d]: actual %b required %b", k, gnt, 4'b0001 << exp_tab[k]); end
                sb.push_back({2'(exp_tab[k]), dsel(exp_tab[k])});
            end
            @(posedge clk); #1;
            if (exp_tab[k] < 0) begin
                n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL drop_valid[%0d]: actual %b required 0", k, out_valid); end
            end else begin
                pop_exp();
                n_cmp++; if ({out_src, out_data} !== exp_q) begin n_err++; $display("FAIL drop_out[%0d]: actual %h required %h", k, {out_src, out_data}, exp_q); end
            end
        end
    endtask
`endif

    task automatic test_reset_mid_burst();
        req = 4'b0010; last = 4'b0000; out_ready = 1'b1;
        rand_d();
        @(negedge clk);
        n_cmp++; if (gnt !== 4'b0010) begin n_err++; $display("FAIL mrst_gnt: actual %b required 0010", gnt); end
        sb.push_back({2'd1, d1});
        @(posedge clk); #1;
        pop_exp();
        n_cmp++; if ({out_valid, out_src, out_data} !== {1'b1, exp_q}) begin n_err++; $display("FAIL mrst_out: actual %h required %h", {out_valid, out_src, out_data}, {1'b1, exp_q}); end
        out_ready = 1'b0;
        #1;
        reset_n = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mrst_valid: actual %b required 0", out_valid); end
        n_cmp++; if (sel !== 3'b000)     begin n_err++; $display("FAIL mrst_sel: actual %b required 000", sel); end
        n_cmp++; if (gnt !== 4'b0000)    begin n_err++; $display("FAIL mrst_gnt_low: actual %b required 0000", gnt); end
        @(posedge clk); #1;
        reset_n = 1'b1;
        req = 4'b1111; last = 4'b1111; out_ready = 1'b1;
        rand_d();
        @(negedge clk);
        n_cmp++; if (gnt !== 4'b0001) begin n_err++; $display("FAIL mrst_restart_gnt: actual %b required 0001", gnt); end
        sb.push_back({2'd0, d0});
        @(posedge clk); #1;
        pop_exp();
        n_cmp++; if ({out_src, out_data} !== exp_q) begin n_err++; $display("FAIL mrst_restart_out: actual %h required %h", {out_src, out_data}, exp_q); end
        req = 4'b0000;
    endtask

    initial begin
        reset_n = 1'b0; req = '0; last = '0; out_ready = 1'b0;
        d0 = '0; d1 = '0; d2 = '0; d3 = '0;
        held = '0; exp_q = '0;
        test_reset();
        test_round_robin();
        test_backpressure();
        test_burst_mix();
`ifdef MUX4H_ARB_BURST_EN
        test_owner_drop();
`endif
        test_reset_mid_burst();
        n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL scoreboard_leftover: actual %0d required 0", sb.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
